// File: rtl/serial_target.sv
// serial_target: oversampling serial-bus target with device-address match and a DEPTH-word register file.
// Optional ACK bit slot after the index field, enabled by defining SERIAL_TARGET_ACK_EN.
module serial_target #(
  parameter int                ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h2A,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SEL,
  input  logic              SCK,
  input  logic              RX,
  output logic              TX,
  output logic              TX_EN,
  input  logic              LW_EN,
  input  logic [IDX_W-1:0]  LW_IDX,
  input  logic [DATA_W-1:0] LW_DATA,
  output logic              WR_STB,
  output logic [IDX_W-1:0]  WR_IDX,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              BUSY
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ((ADDR_W > IDX_W) ? ADDR_W : IDX_W)
                                           : ((DATA_W > IDX_W) ? DATA_W : IDX_W);
  localparam int               CNT_W   = $clog2(MAX_W + 1);
  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CMD, S_IDX, S_ACK, S_DATA, S_DONE, S_IGNORE
  } state_t;

  logic [1:0]        r_sel_s, r_sck_s, r_rx_s;
  logic              r_sel_prev, r_sck_prev;
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_addr_sh;
  logic              r_rw, w_rw_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_sh, w_rd_idx;
  logic [DATA_W-1:0] r_data, w_data_nxt, w_data_sh;
  logic [DATA_W-1:0] r_tx_sh, w_tx_sh_nxt, w_rd_word;
  logic              r_tx, w_tx_nxt, r_tx_en, w_tx_en_nxt;
  logic              r_wr_stb, w_wr_fire, w_wr_ok, w_lw_ok, w_rd_ok;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic [DATA_W-1:0] r_regs [DEPTH];

  logic w_sel, w_sel_rise, w_rise, w_fall, w_rx;

  // SEL sync resets high so a frame already in progress at reset release cannot fake a rise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sel_s    <= 2'b11;
      r_sel_prev <= 1'b1;
      r_sck_s    <= '0;
      r_sck_prev <= 1'b0;
      r_rx_s     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep each flop stage sampling the previous stage's old value.
      r_sel_s    <= {r_sel_s[0], SEL};
      r_sel_prev <= r_sel_s[1];
      r_sck_s    <= {r_sck_s[0], SCK};
      r_sck_prev <= r_sck_s[1];
      r_rx_s     <= {r_rx_s[0], RX};
    end
  end

  assign w_sel      = r_sel_s[1];
  assign w_sel_rise = w_sel & ~r_sel_prev;
  assign w_rise     = r_sck_s[1] & ~r_sck_prev;
  assign w_fall     = ~r_sck_s[1] & r_sck_prev;
  assign w_rx       = r_rx_s[1];

  assign w_addr_sh = ADDR_W'({w_rx, r_addr} >> 1);
  assign w_idx_sh  = IDX_W'({w_rx, r_idx} >> 1);
  assign w_data_sh = DATA_W'({w_rx, r_data} >> 1);

`ifdef SERIAL_TARGET_ACK_EN
  assign w_rd_idx = r_idx;
`else
  assign w_rd_idx = w_idx_sh;
`endif
  assign w_rd_ok   = ({1'b0, w_rd_idx} < DEPTH_L);
  assign w_rd_word = w_rd_ok ? r_regs[w_rd_idx] : '0;
  assign w_wr_ok   = ({1'b0, r_idx} < DEPTH_L);
  assign w_lw_ok   = ({1'b0, LW_IDX} < DEPTH_L);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_rw_nxt    = r_rw;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_tx_sh_nxt = r_tx_sh;
    w_tx_nxt    = r_tx;
    w_tx_en_nxt = r_tx_en;
    w_wr_fire   = 1'b0;
    case (r_state)
      S_IDLE: if (w_sel_rise) begin
        w_state_nxt = S_ADDR;
        w_cnt_nxt   = '0;
      end
      S_ADDR: if (w_rise) begin
        w_addr_nxt = w_addr_sh;
        if (r_cnt == CNT_W'(ADDR_W - 1)) begin
          w_state_nxt = S_CMD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CMD: if (w_rise) begin
        w_rw_nxt    = w_rx;
        w_state_nxt = (r_addr == DEV_ADDR) ? S_IDX : S_IGNORE;
      end
      S_IDX: if (w_rise) begin
        w_idx_nxt = w_idx_sh;
        if (r_cnt == CNT_W'(IDX_W - 1)) begin
          w_cnt_nxt = '0;
`ifdef SERIAL_TARGET_ACK_EN
          w_state_nxt = S_ACK;
`else
          w_state_nxt = S_DATA;
          w_tx_sh_nxt = w_rd_word;
          w_tx_en_nxt = r_rw;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef SERIAL_TARGET_ACK_EN
      // First fall opens the ACK slot; the second closes it and launches data bit 0 on a read.
      S_ACK: if (w_fall) begin
        if (r_cnt == '0) begin
          w_tx_nxt    = 1'b0;
          w_tx_en_nxt = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          if (r_rw) begin
            w_tx_nxt    = w_rd_word[0];
            w_tx_sh_nxt = w_rd_word >> 1;
            w_tx_en_nxt = 1'b1;
          end else begin
            w_tx_nxt    = 1'b1;
            w_tx_en_nxt = 1'b0;
          end
        end
      end
`endif
      S_DATA: begin
        if (w_fall && r_rw) begin
          w_tx_nxt    = r_tx_sh[0];
          w_tx_sh_nxt = r_tx_sh >> 1;
        end
        if (w_rise) begin
          w_data_nxt = w_data_sh;
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            w_state_nxt = S_DONE;
            w_tx_nxt    = 1'b1;
            w_tx_en_nxt = 1'b0;
            w_wr_fire   = ~r_rw;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE, S_IGNORE: ;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!w_sel) begin
      w_state_nxt = S_IDLE;
      w_tx_nxt    = 1'b1;
      w_tx_en_nxt = 1'b0;
      w_wr_fire   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_idx     <= '0;
      r_data    <= '0;
      r_tx_sh   <= '0;
      r_tx      <= 1'b1;
      r_tx_en   <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_rw     <= w_rw_nxt;
      r_idx    <= w_idx_nxt;
      r_data   <= w_data_nxt;
      r_tx_sh  <= w_tx_sh_nxt;
      r_tx     <= w_tx_nxt;
      r_tx_en  <= w_tx_en_nxt;
      r_wr_stb <= w_wr_fire;
      r_busy   <= (w_state_nxt != S_IDLE);
      if (w_wr_fire) begin
        r_wr_idx  <= r_idx;
        r_wr_data <= w_data_sh;
      end
    end
  end

  // NOTE: the register file is reset because software expects reads of never-written entries to return 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (LW_EN && w_lw_ok) r_regs[LW_IDX] <= LW_DATA;
      // Placed after the local write so a same-index serial write takes priority.
      if (w_wr_fire && w_wr_ok) r_regs[r_idx] <= w_data_sh;
    end
  end

  assign TX      = r_tx;
  assign TX_EN   = r_tx_en;
  assign WR_STB  = r_wr_stb;
  assign WR_IDX  = r_wr_idx;
  assign WR_DATA = r_wr_data;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_serial_target.sv
// tb_serial_target: frame-level bench for serial_target; a word-array model predicts writes and read-back bits.
// Honours SERIAL_TARGET_ACK_EN to add the ACK slot to each frame.
module tb_serial_target;

  localparam int               ADDR_W   = 7;
  localparam int               DATA_W   = 8;
  localparam int               DEPTH    = 4;
  localparam int               IDX_W    = 2;
  localparam logic [ADDR_W-1:0] DEV_ADDR = 7'h2A;
  localparam int               HALF     = 8;
`ifdef SERIAL_TARGET_ACK_EN
  localparam int ACK_BITS = 1;
  localparam bit ACK_ON   = 1'b1;
`else
  localparam int ACK_BITS = 0;
  localparam bit ACK_ON   = 1'b0;
`endif
  localparam int DATA_POS  = ADDR_W + 1 + IDX_W + ACK_BITS;
  localparam int FRAME_LEN = DATA_POS + DATA_W;

  logic              CLK, RST, SEL, SCK, RX, TX, TX_EN, LW_EN, WR_STB, BUSY;
  logic [IDX_W-1:0]  LW_IDX, WR_IDX;
  logic [DATA_W-1:0] LW_DATA, WR_DATA;

  serial_target dut (
    .CLK(CLK), .RST(RST), .SEL(SEL), .SCK(SCK), .RX(RX), .TX(TX), .TX_EN(TX_EN),
    .LW_EN(LW_EN), .LW_IDX(LW_IDX), .LW_DATA(LW_DATA),
    .WR_STB(WR_STB), .WR_IDX(WR_IDX), .WR_DATA(WR_DATA), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int stb_cnt = 0;
  int en_cnt  = 0;
  int exp_stb = 0;
  int lw_wait;
  logic [IDX_W-1:0]  exp_wr_idx  = '0;
  logic [DATA_W-1:0] exp_wr_data = '0;
  logic [DATA_W-1:0] model [DEPTH];

  always @(negedge CLK) begin
    if (WR_STB === 1'b1) stb_cnt++;
    if (TX_EN === 1'b1) en_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic local_write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d);
    @(negedge CLK);
    LW_IDX = idx; LW_DATA = d; LW_EN = 1'b1;
    @(negedge CLK);
    LW_EN = 1'b0;
    if (int'(idx) < DEPTH) model[idx] = d;
  endtask

  // Bit-bangs one frame (or its first nbits bits) and checks TX/TX_EN before every SCK rise.
  task automatic frame(input logic [ADDR_W-1:0] addr, input logic rw, input logic [IDX_W-1:0] idx,
                       input logic [DATA_W-1:0] data, input int nbits, input bit keep_sel);
    logic [FRAME_LEN-1:0] fb;
    logic [DATA_W-1:0]    exp_rd;
    bit match;
    int en0;
    match  = (addr == DEV_ADDR);
    exp_rd = (int'(idx) < DEPTH) ? model[idx] : '0;
    fb = '0;
    for (int i = 0; i < ADDR_W; i++) fb[i] = addr[i];
    fb[ADDR_W] = rw;
    for (int i = 0; i < IDX_W; i++)  fb[ADDR_W + 1 + i] = idx[i];
    for (int i = 0; i < DATA_W; i++) fb[DATA_POS + i] = data[i];
    en0 = en_cnt;
    @(negedge CLK);
    SEL = 1'b1; SCK = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      RX = fb[i];
      repeat (HALF) @(negedge CLK);
`ifdef SERIAL_TARGET_ACK_EN
      if (match && i == DATA_POS - 1) begin
        check("ack_tx", TX, 1'b0);
        check("ack_en", TX_EN, 1'b1);
      end else
`endif
      if (match && rw && i >= DATA_POS) begin
        check("rd_bit", TX, exp_rd[i - DATA_POS]);
        check("rd_en", TX_EN, 1'b1);
      end else begin
        check("no_drive", TX_EN, 1'b0);
      end
      SCK = 1'b1;
      repeat (HALF) @(negedge CLK);
      SCK = 1'b0;
    end
    if (keep_sel) return;
    if (nbits == FRAME_LEN) begin
      repeat (HALF) @(negedge CLK);
      check("done_tx", TX, 1'b1);
      check("done_en", TX_EN, 1'b0);
      check("busy_frame", BUSY, 1'b1);
      if (match && !rw) begin
        exp_stb++;
        exp_wr_idx  = idx;
        exp_wr_data = data;
        if (int'(idx) < DEPTH) model[idx] = data;
      end
    end
    @(posedge CLK); #1;
    SEL = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("busy_drop", BUSY, 1'b0);
    repeat (4) @(negedge CLK);
    check("stb_cnt", stb_cnt, exp_stb);
    check("wr_idx", WR_IDX, exp_wr_idx);
    check("wr_data", WR_DATA, exp_wr_data);
    if (nbits == FRAME_LEN) check("en_seen", en_cnt != en0, match && (rw || ACK_ON));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    logic              rrw;
    logic [IDX_W-1:0]  ri;
    logic [DATA_W-1:0] rd;

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    RST = 1'b1; SEL = 1'b0; SCK = 1'b0; RX = 1'b0;
    LW_EN = 1'b0; LW_IDX = '0; LW_DATA = '0;

    // Reset held two cycles with SCK toggling.
    repeat (2) begin
      @(posedge CLK);
      @(negedge CLK);
      SCK = ~SCK;
    end
    check("rst_tx", TX, 1'b1);
    check("rst_tx_en", TX_EN, 1'b0);
    check("rst_wr_stb", WR_STB, 1'b0);
    check("rst_wr_idx", WR_IDX, '0);
    check("rst_wr_data", WR_DATA, '0);
    check("rst_busy", BUSY, 1'b0);
    RST = 1'b0; SCK = 1'b0;
    repeat (6) @(negedge CLK);

    // Serial write then read-back.
    frame(7'h2A, 1'b0, 2'd2, 8'hA5, FRAME_LEN, 1'b0);
    frame(7'h2A, 1'b1, 2'd2, 8'h00, FRAME_LEN, 1'b0);

    // Local load then serial read.
    local_write(2'd1, 8'h3C);
    frame(7'h2A, 1'b1, 2'd1, 8'h00, FRAME_LEN, 1'b0);

    // Address mismatch leaves register 0 alone.
    frame(7'h2B, 1'b0, 2'd0, 8'hFF, FRAME_LEN, 1'b0);
    frame(7'h2A, 1'b1, 2'd0, 8'h00, FRAME_LEN, 1'b0);

    // Abort after three data bits, then a normal frame.
    frame(7'h2A, 1'b0, 2'd0, 8'h77, DATA_POS + 3, 1'b0);
    frame(7'h2A, 1'b1, 2'd0, 8'h00, FRAME_LEN, 1'b0);
    frame(7'h2A, 1'b0, 2'd0, 8'h5A, FRAME_LEN, 1'b0);
    frame(7'h2A, 1'b1, 2'd0, 8'h00, FRAME_LEN, 1'b0);

    // Collision: local write held until the serial write strobe shows up.
    fork
      frame(7'h2A, 1'b0, 2'd3, 8'h11, FRAME_LEN, 1'b0);
      begin
        @(negedge CLK);
        LW_IDX = 2'd3; LW_DATA = 8'h22; LW_EN = 1'b1;
        lw_wait = 0;
        while (WR_STB !== 1'b1 && lw_wait < 2000) begin
          @(posedge CLK); #1;
          lw_wait++;
        end
        LW_EN = 1'b0;
        check("coll_strobe_seen", lw_wait < 2000, 1'b1);
      end
    join
    frame(7'h2A, 1'b1, 2'd3, 8'h00, FRAME_LEN, 1'b0);

    // Randomised traffic against the model.
    for (int n = 0; n < 10; n++) begin
      ra  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : DEV_ADDR;
      rrw = 1'($urandom);
      ri  = IDX_W'($urandom);
      rd  = DATA_W'($urandom);
      if ($urandom_range(0, 2) == 0) local_write(IDX_W'($urandom), DATA_W'($urandom));
      frame(ra, rrw, ri, rd, FRAME_LEN, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) frame(DEV_ADDR, 1'b1, IDX_W'(i), 8'h00, FRAME_LEN, 1'b0);

    // Reset in the middle of a frame with SEL still high.
    frame(7'h2A, 1'b1, 2'd2, 8'h00, 5, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_wr_idx  = '0;
    exp_wr_data = '0;
    repeat (20) @(negedge CLK);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_tx_en", TX_EN, 1'b0);
    check("midrst_wr_data", WR_DATA, '0);
    SEL = 1'b0;
    repeat (6) @(negedge CLK);
    frame(7'h2A, 1'b1, 2'd3, 8'h00, FRAME_LEN, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_target.md
# serial_target

Parametrised serial target (slave) for the serial bus: oversamples the master-generated bus clock `SCK` in the local `CLK` domain, matches a configurable device address, then serves a write or read of one word in an internal register file of `DEPTH` entries. It is the next generation of the original 8-bit address-compare slave. New over that block: framing, a read/write bit, register indexing, and a local-side load port for read data.

## Interface
- `ADDR_W`, 7: device address field width (bits on the wire).
- `DEV_ADDR`, 7'h2A: this target's address.
- `DATA_W`, 8: data word width.
- `DEPTH`, 4: register file entries; index field width `IDX_W = max(1, $clog2(DEPTH))`.
- `CLK` input 1: local clock; all logic on rising edge.
- `RST` input 1: synchronous, active-high reset.
- `SEL` input 1: frame select from master, active high (asynchronous to `CLK`).
- `SCK` input 1: bus clock from master (asynchronous to `CLK`).
- `RX` input 1: serial data from master.
- `TX` output 1: serial data to master.
- `TX_EN` output 1: `TX` drive enable; 0 = released.
- `LW_EN` input 1: local write strobe into the register file.
- `LW_IDX` input `IDX_W`: local write index.
- `LW_DATA` input `DATA_W`: local write data.
- `WR_STB` output 1: one-cycle pulse on completion of a serial write.
- `WR_IDX` output `IDX_W`: index of that write.
- `WR_DATA` output `DATA_W`: data of that write.
- `BUSY` output 1: frame in progress (state not IDLE).

## Operation
- `SEL`, `SCK` and `RX` each pass through 2-flop synchronisers. Rise/fall of `SCK` are detected from the synchronised copies. `RX` is sampled on the detected `SCK` rise.
- Frame, all fields sent LSB first: `ADDR_W` address bits, 1 R/W bit (1 = read), `IDX_W` index bits, then `DATA_W` data bits.
- States:
  - IDLE → ADDR on synchronised `SEL` rise.
  - ADDR → CMD after `ADDR_W` bits.
  - CMD: captures the R/W bit, then goes to IDX if the address matched `DEV_ADDR`, else to IGNORE.
  - IDX → (ACK) → DATA.
  - DATA → DONE after `DATA_W` bits.
  - IGNORE and DONE discard further `SCK` edges.
- Any state → IDLE whenever synchronised `SEL` is low. A partial frame is dropped: no `WR_STB`, no register change.
- Write: on the last data-bit rise, if index < `DEPTH`, write the register and pulse `WR_STB` for 1 `CLK`. `WR_IDX`/`WR_DATA` hold until the next write. Index ≥ `DEPTH`: `WR_STB` still pulses, register file unchanged.
- Read: at entry to DATA, snapshot `reg[idx]` into the shift register; an index ≥ `DEPTH` snapshots 0.
  - `TX_EN` is 1 in DATA only.
  - Bit 0 is driven on the `SCK` fall that precedes the first data rise; each later bit is driven on the following `SCK` fall.
  - `TX_EN` drops and `TX` returns to 1 on entry to DONE.
- Local write: `LW_EN` writes `reg[LW_IDX]` when `LW_IDX` < `DEPTH`, else it is ignored. If `LW_EN` and a serial write hit the same index in the same cycle, the serial write wins. A local write during a read never alters the snapshot.
- Address mismatch: `TX_EN` stays 0 for the whole frame; registers untouched.

## Timing
- Reset values:
  - `TX`=1, `TX_EN`=0, `WR_STB`=0, `WR_IDX`=0, `WR_DATA`=0, `BUSY`=0.
  - State IDLE, counters 0, register file all 0.
- `RST` mid-frame aborts the frame immediately; the next frame needs a fresh `SEL` rise.
- Latency from `SCK` pin edge to internal edge detect: 3 `CLK`. `RX` is aligned through the same synchroniser depth.
- `WR_STB` asserts 1 `CLK` after the detected final data rise.
- `TX` updates 1 `CLK` after the detected `SCK` fall, i.e. ≤4 `CLK` after the pin fall.
- Master constraint: `SCK` high and low phases are each ≥ 6 `CLK` periods. `SEL` rises ≥ 4 `CLK` before the first `SCK` rise.
- `BUSY` follows state with 1 `CLK` registration.

## Configuration
- `SERIAL_TARGET_ACK_EN` defined:
  - Adds an ACK bit slot after the index field, with state ACK between IDX and DATA.
  - On a match, `TX`=0 and `TX_EN`=1 from the `SCK` fall after the last index bit until the next `SCK` fall.
  - The frame grows by one bit.
  - On a read, data bit 0 is driven on the fall that ends ACK.
- Undefined: no ACK state; frame length is `ADDR_W+1+IDX_W+DATA_W`.

## Test plan
- Reset: assert `RST` 2 cycles with `SCK` toggling → all outputs at reset values, `BUSY`=0.
- Serial write: addr 0x2A, W, idx 2, data 0xA5 → one `WR_STB`, `WR_IDX`=2, `WR_DATA`=0xA5; a following read of idx 2 returns 0xA5 LSB first.
- Local load then read: `LW_EN` idx 1 = 0x3C; serial read idx 1 → `TX` bits 0,0,1,1,1,1,0,0 with `TX_EN`=1 in DATA only.
- Mismatch: addr 0x2B, W, idx 0, data 0xFF → `TX_EN` never 1, no `WR_STB`, reg 0 unchanged.
- Abort: `SEL` low after 3 data bits of a write → no `WR_STB`, `BUSY`=0 within 3 `CLK`; the next full frame is handled normally.
- Collision, plus ACK if compiled: serial write 0x11 and `LW_EN` 0x22 to idx 3 in the same cycle → reg 3 = 0x11. With `SERIAL_TARGET_ACK_EN`, `TX`=0 during the ACK slot on a match.
